morph_line_sched: RTL and testbench

//  Sequencer for the 4-line binary morphology datapath (erode/dilate kernel). Decodes VTC

---
 rtl/morph_line_sched.sv | 129 ++++++++++++
 tb/tb_morph_line_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_line_sched.sv
// Line-buffer sequencer for the 4-line binary morphology kernel: decodes VTC counts into
// frame/line events, rotates bank writes, qualifies the window and syncs mode to frames.
module morph_line_sched #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned KSIZE    = 4,
  parameter int unsigned BORDER   = 2
) (
  input  logic        PCLK,
  input  logic        RST_N,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic        mode_wr_i,
  output logic        frame_start_o,
  output logic        line_start_o,
  output logic [3:0]  lb_wr_sel_o,
  output logic [9:0]  lb_wr_addr_o,
  output logic [1:0]  lb_rd_ptr_o,
  output logic        win_valid_o,
  output logic [1:0]  mode_o,
  output logic [7:0]  frame_cnt_o,
  output logic        busy_o
);

  localparam logic [11:0] HAct     = 12'(H_ACTIVE);
  localparam logic [11:0] VAct     = 12'(V_ACTIVE);
  localparam logic [11:0] HBrdLo   = 12'(BORDER);
  localparam logic [11:0] HBrdHi   = 12'(H_ACTIVE - BORDER);
  localparam logic [11:0] VBrdLo   = 12'(BORDER);
  localparam logic [11:0] VBrdHi   = 12'(V_ACTIVE - BORDER);
  localparam logic [1:0]  RowsFull = 2'(KSIZE - 1);

  typedef enum logic [1:0] {StIdle, StWaitFrame, StActive, StVblank} state_e;

  state_e      state_q, state_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rows_q, rows_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        fs, ls, act, accept, in_border;
  logic        fstart_d, lstart_d, win_d, busy_d;
  logic [3:0]  sel_d;

  assign fs        = (VtcHCnt == '0) && (VtcVCnt == '0);
  assign ls        = (VtcHCnt == '0) && (VtcVCnt < VAct);
  assign act       = (VtcHCnt < HAct) && (VtcVCnt < VAct);
  assign in_border = (VtcHCnt >= HBrdLo) && (VtcHCnt < HBrdHi) &&
                     (VtcVCnt >= VBrdLo) && (VtcVCnt < VBrdHi);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StWaitFrame;
      end
      StWaitFrame, StVblank: begin
        if (fs) begin
          if (en_i) accept = 1'b1;
          else      state_d = StIdle;
        end
      end
      StActive: begin
        // A jump to (0,0) mid-frame is a VTC restart and is handled like a normal fs.
        if (fs) begin
          if (en_i) accept = 1'b1;
          else      state_d = StIdle;
        end else if (VtcVCnt == VAct) begin
          state_d = StVblank;
        end
      end
    endcase
    if (accept) state_d = StActive;

    mode_d   = accept ? ((pend_q == 2'b11) ? 2'b00 : pend_q) : mode_q;
    pend_d   = mode_wr_i ? mode_i : pend_q;
    fcnt_d   = accept ? fcnt_q + 8'd1 : fcnt_q;
    wr_ptr_d = accept ? 2'd0 : wr_ptr_q;
    rows_d   = accept ? 2'd0 : rows_q;
    if ((state_d == StActive) && ls && (VtcVCnt != '0)) begin
      wr_ptr_d = wr_ptr_d + 2'd1;
      if (rows_d != RowsFull) rows_d = rows_d + 2'd1;
    end

    fstart_d = accept;
    lstart_d = (state_d == StActive) && ls;
    sel_d    = ((state_d == StActive) && act) ? (4'b0001 << wr_ptr_d) : 4'b0000;
    win_d    = (state_d == StActive) && (mode_d != 2'b00) && (rows_d == RowsFull) && in_border;
    busy_d   = (state_d == StActive) || (state_d == StVblank);
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      wr_ptr_q      <= 2'd0;
      rows_q        <= 2'd0;
      pend_q        <= 2'd0;
      mode_q        <= 2'd0;
      fcnt_q        <= 8'd0;
      frame_start_o <= 1'b0;
      line_start_o  <= 1'b0;
      lb_wr_sel_o   <= 4'd0;
      lb_wr_addr_o  <= 10'd0;
      win_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rows_q        <= rows_d;
      pend_q        <= pend_d;
      mode_q        <= mode_d;
      fcnt_q        <= fcnt_d;
      frame_start_o <= fstart_d;
      line_start_o  <= lstart_d;
      lb_wr_sel_o   <= sel_d;
      lb_wr_addr_o  <= VtcHCnt[9:0];
      win_valid_o   <= win_d;
      busy_o        <= busy_d;
    end
  end

  assign lb_rd_ptr_o = wr_ptr_q;
  assign mode_o      = mode_q;
  assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_morph_line_sched.sv
// Scoreboard bench for morph_line_sched on a reduced 16x12 raster (18x13 total timing).
module tb_morph_line_sched;

  localparam int HA = 16;
  localparam int VA = 12;
  localparam int HT = 18;
  localparam int VT = 13;
  localparam int BD = 2;
  localparam int KS = 4;
  localparam int WIN_PER_FRAME = (HA - 2 * BD) * (VA - 2 * BD - 1);

  logic        PCLK, RST_N;
  logic [11:0] VtcHCnt, VtcVCnt;
  logic        en_i, mode_wr_i;
  logic [1:0]  mode_i;
  logic        frame_start_o, line_start_o, win_valid_o, busy_o;
  logic [3:0]  lb_wr_sel_o;
  logic [9:0]  lb_wr_addr_o;
  logic [1:0]  lb_rd_ptr_o, mode_o;
  logic [7:0]  frame_cnt_o;

  morph_line_sched #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .KSIZE   (KS),
    .BORDER  (BD)
  ) dut (
    .PCLK         (PCLK),
    .RST_N        (RST_N),
    .VtcHCnt      (VtcHCnt),
    .VtcVCnt      (VtcVCnt),
    .en_i         (en_i),
    .mode_i       (mode_i),
    .mode_wr_i    (mode_wr_i),
    .frame_start_o(frame_start_o),
    .line_start_o (line_start_o),
    .lb_wr_sel_o  (lb_wr_sel_o),
    .lb_wr_addr_o (lb_wr_addr_o),
    .lb_rd_ptr_o  (lb_rd_ptr_o),
    .win_valid_o  (win_valid_o),
    .mode_o       (mode_o),
    .frame_cnt_o  (frame_cnt_o),
    .busy_o       (busy_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] sb[$];
  logic [29:0] exp_v;

  // Reference model state: 0 idle, 1 wait-frame, 2 active, 3 vblank.
  int m_st, m_ptr, m_rows, m_pend, m_mode, m_fcnt;

  function automatic logic [29:0] pack_obs();
    return {frame_start_o, line_start_o, lb_wr_sel_o, lb_wr_addr_o, lb_rd_ptr_o,
            win_valid_o, mode_o, frame_cnt_o, busy_o};
  endfunction

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_rows = 0; m_pend = 0; m_mode = 0; m_fcnt = 0;
    sb.delete();
  endtask

  task automatic model_step(input int h, input int v);
    bit fs, ls, act, acc, win;
    logic [3:0] sel;
    fs  = (h == 0) && (v == 0);
    ls  = (h == 0) && (v < VA);
    act = (h < HA) && (v < VA);
    acc = 0;
    case (m_st)
      0: if (en_i) m_st = 1;
      2: begin
        if (fs) begin
          if (en_i) acc = 1; else m_st = 0;
        end else if (v == VA) m_st = 3;
      end
      default: if (fs) begin
        if (en_i) acc = 1; else m_st = 0;
      end
    endcase
    if (acc) begin
      m_st = 2; m_mode = (m_pend == 3) ? 0 : m_pend;
      m_ptr = 0; m_rows = 0; m_fcnt = (m_fcnt + 1) % 256;
    end
    if (mode_wr_i) m_pend = int'(mode_i);
    if (m_st == 2 && ls && v != 0) begin
      m_ptr = (m_ptr + 1) % 4;
      if (m_rows < KS - 1) m_rows = m_rows + 1;
    end
    sel = (m_st == 2 && act) ? 4'(1 << m_ptr) : 4'b0000;
    win = (m_st == 2) && (m_mode != 0) && (m_rows == KS - 1) &&
          (h >= BD) && (h < HA - BD) && (v >= BD) && (v < VA - BD);
    sb.push_back({1'(acc), 1'(m_st == 2 && ls), sel, 10'(h), 2'(m_ptr), 1'(win),
                  2'(m_mode), 8'(m_fcnt), 1'(m_st == 2 || m_st == 3)});
  endtask

  // Drive one pixel position, record its expectation, and advance past the sampling edge.
  task automatic tick(input int h, input int v);
    VtcHCnt = 12'(h);
    VtcVCnt = 12'(v);
    model_step(h, v);
    @(posedge PCLK);
    #1;
    mode_wr_i = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b1; en_i = 1'b0; mode_i = 2'b00; mode_wr_i = 1'b0;
    VtcHCnt = 12'd0; VtcVCnt = 12'd0;
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (pack_obs() !== 30'd0) begin
      n_fail++; $display("FAIL reset_init: got %h want 0", pack_obs());
    end
    @(negedge PCLK) RST_N = 1'b1;
    en_i = 1'b1;
    for (int h = 5; h < HT; h++) begin
      tick(h, 5);
      exp_v = sb.pop_front(); n_checks++;
      if (pack_obs() !== exp_v) begin
        n_fail++; $display("FAIL reset_prefs obs=%h exp=%h", pack_obs(), exp_v);
      end
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_active_before_fs: busy %b want 0", busy_o);
    end
    for (int v = 0; v < 5; v++)
      for (int h = 0; h < HT; h++) begin
        if (v == 4 && h == 8) break;
        tick(h, v);
        exp_v = sb.pop_front(); n_checks++;
        if (pack_obs() !== exp_v) begin
          n_fail++; $display("FAIL reset_frame obs=%h exp=%h", pack_obs(), exp_v);
        end
      end
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_mid: busy %b want 1", busy_o);
    end
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (pack_obs() !== 30'd0) begin
      n_fail++; $display("FAIL reset_async_mid: got %h want 0", pack_obs());
    end
    @(negedge PCLK) RST_N = 1'b1;
    for (int h = 8; h < HT; h++) begin
      tick(h, 4);
      exp_v = sb.pop_front(); n_checks++;
      if (pack_obs() !== exp_v) begin
        n_fail++; $display("FAIL reset_resume obs=%h exp=%h", pack_obs(), exp_v);
      end
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_after: busy %b want 0", busy_o);
    end
  endtask

  task automatic test_rotation();
    int rd_tab[6];
    int sel_tab[6];
    rd_tab  = '{0, 1, 2, 3, 0, 1};
    sel_tab = '{1, 2, 4, 8, 1, 2};
    mode_i = 2'b01; mode_wr_i = 1'b1;
    tick(HT - 1, VA);
    void'(sb.pop_front());
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        tick(h, v);
        exp_v = sb.pop_front(); n_checks++;
        if (pack_obs() !== exp_v) begin
          n_fail++; $display("FAIL rotation obs=%h exp=%h", pack_obs(), exp_v);
        end
        if (v < 6 && h == 0) begin
          n_checks++;
          if (int'(lb_rd_ptr_o) != rd_tab[v]) begin
            n_fail++; $display("FAIL rotation_rd_ptr v=%0d got %0d want %0d", v, lb_rd_ptr_o,
                               rd_tab[v]);
          end
        end
        if (v < 6 && h == 1) begin
          n_checks++;
          if (int'(lb_wr_sel_o) != sel_tab[v]) begin
            n_fail++; $display("FAIL rotation_wr_sel v=%0d got %b want %0d", v, lb_wr_sel_o,
                               sel_tab[v]);
          end
        end
      end
  endtask

  task automatic test_window();
    int wins = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        tick(h, v);
        exp_v = sb.pop_front(); n_checks++;
        if (pack_obs() !== exp_v) begin
          n_fail++; $display("FAIL window obs=%h exp=%h", pack_obs(), exp_v);
        end
        if (win_valid_o === 1'b1) wins++;
      end
    n_checks++;
    if (wins != WIN_PER_FRAME) begin
      n_fail++; $display("FAIL window_count got %0d want %0d", wins, WIN_PER_FRAME);
    end
  endtask

  task automatic test_mode_sync();
    int mode_at_fs[4];
    int wr_val[4];
    int wr_v[4];
    mode_at_fs = '{1, 2, 0, 1};
    wr_val     = '{2, 3, 1, -1};
    wr_v       = '{6, 6, 0, -1};
    for (int f = 0; f < 4; f++) begin
      int wins = 0;
      for (int v = 0; v < VT; v++)
        for (int h = 0; h < HT; h++) begin
          if (h == 0 && v == wr_v[f]) begin
            mode_i = 2'(wr_val[f]); mode_wr_i = 1'b1;
          end
          tick(h, v);
          exp_v = sb.pop_front(); n_checks++;
          if (pack_obs() !== exp_v) begin
            n_fail++; $display("FAIL mode_sync f=%0d obs=%h exp=%h", f, pack_obs(), exp_v);
          end
          if (win_valid_o === 1'b1) wins++;
          if (h == 0 && v == 0) begin
            n_checks++;
            if (int'(mode_o) != mode_at_fs[f]) begin
              n_fail++; $display("FAIL mode_at_fs f=%0d got %0d want %0d", f, mode_o,
                                 mode_at_fs[f]);
            end
          end
        end
      n_checks++;
      if (wins != ((f == 2) ? 0 : WIN_PER_FRAME)) begin
        n_fail++; $display("FAIL mode_win_count f=%0d got %0d", f, wins);
      end
    end
  endtask

  task automatic test_enable();
    int fc_hold;
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < VT; v++)
        for (int h = 0; h < HT; h++) begin
          if (f == 0 && v == 8 && h == 0) en_i = 1'b0;
          if (f == 0 && v == 8 && h == 0) fc_hold = m_fcnt;
          tick(h, v);
          exp_v = sb.pop_front(); n_checks++;
          if (pack_obs() !== exp_v) begin
            n_fail++; $display("FAIL enable obs=%h exp=%h", pack_obs(), exp_v);
          end
          if (f == 0 && v == VA - 1 && h == 1) begin
            n_checks++;
            if (busy_o !== 1'b1) begin
              n_fail++; $display("FAIL enable_frame_completes busy %b want 1", busy_o);
            end
          end
          if (f == 1 && h == 0 && (v == 0 || v == 5)) begin
            n_checks++;
            if (busy_o !== 1'b0 || int'(frame_cnt_o) != fc_hold) begin
              n_fail++; $display("FAIL enable_stop busy %b cnt %0d want 0 %0d", busy_o,
                                 frame_cnt_o, fc_hold);
            end
          end
        end
  endtask

  task automatic test_wrap();
    int exp_fc;
    int wins = 0;
    bit saw_wrap = 0;
    en_i = 1'b1;
    tick(5, VA);
    void'(sb.pop_front());
    exp_fc = m_fcnt;
    for (int k = 0; k < 260; k++) begin
      for (int h = 0; h < 2; h++) begin
        tick(h, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (pack_obs() !== exp_v) begin
          n_fail++; $display("FAIL wrap obs=%h exp=%h", pack_obs(), exp_v);
        end
      end
      if (exp_fc == 255) saw_wrap = 1'b1;
      exp_fc = (exp_fc + 1) % 256;
      if (exp_fc == 0 && saw_wrap) begin
        n_checks++;
        if (frame_cnt_o !== 8'd0) begin
          n_fail++; $display("FAIL wrap_255_to_0 got %0d want 0", frame_cnt_o);
        end
      end
    end
    n_checks++;
    if (int'(frame_cnt_o) != exp_fc || !saw_wrap) begin
      n_fail++; $display("FAIL wrap_final got %0d want %0d", frame_cnt_o, exp_fc);
    end
    for (int v = 0; v < 8; v++)
      for (int h = 0; h < HT; h++) begin
        tick(h, v);
        exp_v = sb.pop_front(); n_checks++;
        if (pack_obs() !== exp_v) begin
          n_fail++; $display("FAIL restart_pre obs=%h exp=%h", pack_obs(), exp_v);
        end
      end
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        tick(h, v);
        exp_v = sb.pop_front(); n_checks++;
        if (pack_obs() !== exp_v) begin
          n_fail++; $display("FAIL restart obs=%h exp=%h", pack_obs(), exp_v);
        end
        if (win_valid_o === 1'b1) wins++;
        if (v == 0 && h == 0) begin
          n_checks++;
          if (lb_rd_ptr_o !== 2'd0 || frame_start_o !== 1'b1) begin
            n_fail++; $display("FAIL restart_ptr got ptr %0d fs %b want 0 1", lb_rd_ptr_o,
                               frame_start_o);
          end
        end
      end
    n_checks++;
    if (wins != WIN_PER_FRAME) begin
      n_fail++; $display("FAIL restart_win_count got %0d want %0d", wins, WIN_PER_FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_window();
    test_mode_sync();
    test_enable();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
